alu_vec_element: RTL and testbench
==================================

// Module: alu_vec_element
// PURPOSE
//   Single-lane integer ALU: one ELEMENT_SIZE-bit element of the vector datapath.
//   The vector ALU instantiates one per lane and drives all lanes with a common opcode.
//   Combinational compute with a registered result: 1-cycle latency, flags alongside.
// PARAMETERS
//   ELEMENT_SIZE  16  lane width in bits (>=2); all operands and the result use it
// PORTS
//   clk        in   1             rising-edge clock
//   rst        in   1             synchronous, active-high reset
//   in_valid   in   1             operands/opcode valid this cycle
//   elementA   in   ELEMENT_SIZE  operand A (unsigned; signed view for SUB/overflow)
//   elementB   in   ELEMENT_SIZE  operand B
//   opcode     in   3             operation select (table below)
//   result     out  ELEMENT_SIZE  registered result
//   out_valid  out  1             result/flags valid (in_valid delayed 1 cycle)
//   zero       out  1             result == 0
//   carry      out  1             carry-out (ADD), borrow (SUB), last bit shifted out (SHL/SHR), else 0
//   overflow   out  1             signed overflow (ADD/SUB); MUL: high half nonzero; else 0
// BEHAVIOUR
//   - Clock and reset: one clock, clk; rst is synchronous and active-high.
//   - Opcodes:
//       000 ADD  A+B mod 2^N
//       001 SUB  A-B mod 2^N
//       010 MUL  low N bits of A*B
//       011 AND
//       100 OR
//       101 XOR
//       110 SHL  A << B[log2(N)-1:0]
//       111 SHR  logical A >> B[log2(N)-1:0]
//   - Shift amount: uses only the low clog2(N) bits of B; shift by 0 -> result=A, carry=0.
//   - Capture: on a clk edge with in_valid=1 and rst=0, result/flags are loaded from
//     the current inputs, and out_valid=1 the following cycle.
//   - in_valid=0: result/flags hold their previous values; out_valid=0 next cycle.
//   - Latency: exactly 1 cycle; back-to-back issue every cycle is supported (no stall).
//   - Reset: rst=1 at a clk edge forces result=0, zero=1, carry=0, overflow=0,
//     out_valid=0. Reset wins over a simultaneous in_valid; any in-flight op is discarded.
//   - Arithmetic widths: internal sum/difference is N+1 bits; the product is 2N bits.
//       * ADD carry = bit N of the sum.
//       * SUB carry = 1 when A<B (unsigned borrow).
//       * ADD overflow = A[N-1]==B[N-1] && R[N-1]!=A[N-1].
//       * SUB overflow = A[N-1]!=B[N-1] && R[N-1]!=A[N-1].
//   - Wrap-around: results are always truncated to N bits; nothing saturates.
//   - No X propagation: an undefined opcode is not possible (3-bit space is fully decoded).
// TESTING
//   - ADD: A=8, B=5, op=000, in_valid=1 -> next cycle result=13, out_valid=1, zero=0, carry=0.
//   - ADD wrap: A=16'hFFFF, B=1 -> result=0, zero=1, carry=1, overflow=0;
//     A=16'h7FFF, B=1 -> 16'h8000, overflow=1.
//   - SUB borrow: A=3, B=5, op=001 -> result=16'hFFFE, carry=1;
//     A=16'h8000, B=1 -> 16'h7FFF, overflow=1.
//   - MUL/logic: A=16'h0100, B=16'h0100, op=010 -> result=0, overflow=1;
//     A=16'hF0F0, B=16'h0FF0 -> AND 16'h00F0, OR 16'hFFF0, XOR 16'hFF00.
//   - Shifts: A=16'h8001, B=1, op=110 -> 16'h0002, carry=1;
//     op=111 -> 16'h4000, carry=1; B=16 -> shift 0, result=16'h8001.
//   - Control: three back-to-back valid ops give three consecutive results with out_valid=1;
//     in_valid=0 holds result; rst=1 with in_valid=1 -> result=0, zero=1, out_valid=0 next cycle.

Source files
------------

// File: rtl/alu_vec_element.sv
// One lane of the vector integer ALU: combinational compute with result and flags
// registered. Capture happens on in_valid and out_valid follows one cycle later.
module alu_vec_element #(
  parameter int ELEMENT_SIZE = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [ELEMENT_SIZE-1:0] elementA,
  input  logic [ELEMENT_SIZE-1:0] elementB,
  input  logic [2:0]              opcode,
  output logic [ELEMENT_SIZE-1:0] result,
  output logic                    out_valid,
  output logic                    zero,
  output logic                    carry,
  output logic                    overflow
);

  localparam int N    = ELEMENT_SIZE;
  localparam int SH_W = $clog2(N);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } alu_op_e;

  alu_op_e         op;
  logic [N:0]      sum;
  logic [N:0]      diff;
  logic [2*N-1:0]  prod;
  logic [SH_W-1:0] shamt;
  logic [N:0]      shl_ext;
  logic [N:0]      shr_ext;

  logic [N-1:0]    next_result;
  logic            next_carry;
  logic            next_overflow;

  assign op    = alu_op_e'(opcode);
  assign shamt = elementB[SH_W-1:0];

  // Shifts run on N+1 bits so the last bit shifted out lands in the spare bit
  // (top for SHL, bottom for SHR); a zero shift leaves that bit clear.
  always_comb begin
    sum     = {1'b0, elementA} + {1'b0, elementB};
    diff    = {1'b0, elementA} - {1'b0, elementB};
    prod    = {{N{1'b0}}, elementA} * {{N{1'b0}}, elementB};
    shl_ext = {1'b0, elementA} << shamt;
    shr_ext = {elementA, 1'b0} >> shamt;
  end

  always_comb begin
    next_result   = '0;
    next_carry    = 1'b0;
    next_overflow = 1'b0;
    case (op)
      OP_ADD: begin
        next_result   = sum[N-1:0];
        next_carry    = sum[N];
        next_overflow = (elementA[N-1] == elementB[N-1]) &&
                        (sum[N-1] != elementA[N-1]);
      end
      OP_SUB: begin
        next_result   = diff[N-1:0];
        next_carry    = diff[N];
        next_overflow = (elementA[N-1] != elementB[N-1]) &&
                        (diff[N-1] != elementA[N-1]);
      end
      OP_MUL: begin
        next_result   = prod[N-1:0];
        next_overflow = |prod[2*N-1:N];
      end
      OP_AND: next_result = elementA & elementB;
      OP_OR:  next_result = elementA | elementB;
      OP_XOR: next_result = elementA ^ elementB;
      OP_SHL: begin
        next_result = shl_ext[N-1:0];
        next_carry  = shl_ext[N];
      end
      OP_SHR: begin
        next_result = shr_ext[N:1];
        next_carry  = shr_ext[0];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result    <= '0;
      zero      <= 1'b1;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result   <= next_result;
        zero     <= (next_result == '0);
        carry    <= next_carry;
        overflow <= next_overflow;
      end
    end
  end

endmodule

// File: tb/tb_alu_vec_element.sv
// Directed bench for alu_vec_element (16-bit lane): each step issues one op and
// checks the registered result and flags one cycle later.
module tb_alu_vec_element;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] elementA;
  logic [15:0] elementB;
  logic [2:0]  opcode;
  logic [15:0] result;
  logic        out_valid;
  logic        zero;
  logic        carry;
  logic        overflow;

  int tests = 0;
  int fails = 0;

  alu_vec_element #(.ELEMENT_SIZE(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .elementA (elementA),
    .elementB (elementB),
    .opcode   (opcode),
    .result   (result),
    .out_valid(out_valid),
    .zero     (zero),
    .carry    (carry),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
      $error("%s mismatch", tag);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] r, input logic z,
                           input logic c, input logic o, input logic v);
    chk({tag, ".result"},    result,           r);
    chk({tag, ".zero"},      {15'd0, zero},     {15'd0, z});
    chk({tag, ".carry"},     {15'd0, carry},    {15'd0, c});
    chk({tag, ".overflow"},  {15'd0, overflow}, {15'd0, o});
    chk({tag, ".out_valid"}, {15'd0, out_valid},{15'd0, v});
  endtask

  task automatic drive(input logic r, input logic v, input logic [15:0] a,
                       input logic [15:0] b, input logic [2:0] op);
    rst      = r;
    in_valid = v;
    elementA = a;
    elementB = b;
    opcode   = op;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; elementA = '0; elementB = '0; opcode = 3'b000;
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 16'h0000, 16'h0000, 3'b000);
    check_all("reset", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);

    // Back-to-back issue every cycle
    drive(1'b0, 1'b1, 16'd8,    16'd5,    3'b000);
    check_all("add",      16'd13,   1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 16'hFFFF, 16'h0001, 3'b000);
    check_all("add_wrap", 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 16'h7FFF, 16'h0001, 3'b000);
    check_all("add_ovf",  16'h8000, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 16'd3,    16'd5,    3'b001);
    check_all("sub_brw",  16'hFFFE, 1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 16'h8000, 16'h0001, 3'b001);
    check_all("sub_ovf",  16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 16'h0100, 16'h0100, 3'b010);
    check_all("mul_hi",   16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 16'h00FF, 16'h0101, 3'b010);
    check_all("mul_lo",   16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 16'hF0F0, 16'h0FF0, 3'b011);
    check_all("and",      16'h00F0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 16'hF0F0, 16'h0FF0, 3'b100);
    check_all("or",       16'hFFF0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 16'hF0F0, 16'h0FF0, 3'b101);
    check_all("xor",      16'hFF00, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 16'h8001, 16'h0001, 3'b110);
    check_all("shl1",     16'h0002, 1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 16'h8001, 16'h0001, 3'b111);
    check_all("shr1",     16'h4000, 1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 16'h0003, 16'd15,   3'b110);
    check_all("shl15",    16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 16'h8000, 16'd15,   3'b111);
    check_all("shr15",    16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 16'h8001, 16'd16,   3'b111);
    check_all("shr16",    16'h8001, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 16'h8001, 16'd16,   3'b110);
    check_all("shl16",    16'h8001, 1'b0, 1'b0, 1'b0, 1'b1);

    // Idle: result and flags hold, out_valid drops
    drive(1'b0, 1'b0, 16'h1234, 16'h1234, 3'b001);
    check_all("hold",     16'h8001, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 16'hFFFF, 16'h0001, 3'b000);
    check_all("add_again",16'h0000, 1'b1, 1'b1, 1'b0, 1'b1);

    // Reset beats a simultaneous valid op
    drive(1'b1, 1'b1, 16'd8,    16'd5,    3'b000);
    check_all("rst_win",  16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 16'd5,    16'd5,    3'b001);
    check_all("sub_eq",   16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 16'h0001, 16'h8000, 3'b001);
    check_all("sub_ovf2", 16'h8001, 1'b0, 1'b1, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
